// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, character codes and reader states
package seg7_pkg;

    // Segment bus order is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_H     = 7'b1110110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b0111000;

    localparam logic [3:0] CODE_H = 4'hA;
    localparam logic [3:0] CODE_E = 4'hB;
    localparam logic [3:0] CODE_L = 4'hC;

    typedef enum logic [1:0] {
        BLANK,
        SETTLE,
        LOCKED,
        ERROR
    } seg7_state_t;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/seg7_to_code.sv
// rtl/seg7_to_code.sv - segment pattern to code lookup (SEG7_READER_CHAR_EN adds H/E/L)
module seg7_to_code
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] code
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        code  = 4'd0;
        case (seg)
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            SEG_0: code = 4'd0;
            SEG_1: code = 4'd1;
            SEG_2: code = 4'd2;
            SEG_3: code = 4'd3;
            SEG_4: code = 4'd4;
            SEG_5: code = 4'd5;
            SEG_6: code = 4'd6;
            SEG_7: code = 4'd7;
            SEG_8: code = 4'd8;
            SEG_9: code = 4'd9;
`ifdef SEG7_READER_CHAR_EN
            SEG_H: code = CODE_H;
            SEG_E: code = CODE_E;
            SEG_L: code = CODE_L;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - debounced 7-segment readback decoder (see SEG7_READER_CHAR_EN in seg7_to_code)
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sample_en,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       bad_code,
    output logic [7:0] err_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE_CNT    = CW'(1);

    logic [6:0]  seg_q;
    logic [6:0]  cand;
    logic [CW-1:0] cnt;
    seg7_state_t state;

    logic [6:0]  cand_nxt;
    logic [CW-1:0] cnt_nxt;
    logic        commit;
    logic        dec_legal;
    logic        dec_blank;
    logic [3:0]  dec_code;

    // A commit always happens with cand_nxt == seg_q, so the lookup sees the
    // pattern being committed even when STABLE_CYCLES is 1.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        commit   = 1'b0;
        if (seg_q != cand) begin
            cand_nxt = seg_q;
            cnt_nxt  = ONE_CNT;
            commit   = (STABLE_CNT == ONE_CNT);
        end else if (state == SETTLE && cnt < STABLE_CNT) begin
            cnt_nxt = cnt + ONE_CNT;
            commit  = (cnt_nxt == STABLE_CNT);
        end
    end

    seg7_to_code u_lookup (
        .seg   (cand_nxt),
        .legal (dec_legal),
        .blank (dec_blank),
        .code  (dec_code)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            seg_q       <= SEG_BLANK;
            cand        <= SEG_BLANK;
            cnt         <= STABLE_CNT;
            state       <= BLANK;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            new_digit   <= 1'b0;
            bad_code    <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            seg_q     <= seg_in;
            new_digit <= 1'b0;
            if (sample_en) begin
                cand <= cand_nxt;
                cnt  <= cnt_nxt;
                if (commit) begin
                    if (dec_blank) begin
                        state       <= BLANK;
                        digit_valid <= 1'b0;
                        bad_code    <= 1'b0;
                    end else if (dec_legal) begin
                        state       <= LOCKED;
                        new_digit   <= (dec_code != digit) || !digit_valid;
                        digit       <= dec_code;
                        digit_valid <= 1'b1;
                        bad_code    <= 1'b0;
                    end else begin
                        state       <= ERROR;
                        digit_valid <= 1'b0;
                        bad_code    <= 1'b1;
                        err_count   <= sat_inc8(err_count);
                    end
                end else if (seg_q != cand) begin
                    state <= SETTLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - table, sequence and random checks of seg7_reader against a run-length model
module tb_seg7_reader;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       sample_en = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic [3:0] digit;
    logic       digit_valid, new_digit, bad_code;
    logic [7:0] err_count;

    seg7_reader #(.STABLE_CYCLES(N)) dut (
        .clk(clk), .clr(clr), .sample_en(sample_en), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
        .bad_code(bad_code), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a pattern is committed on the sample where its run of equal
    // consecutive samples first reaches N.
    logic [6:0] m_segq;
    logic [6:0] run_val;
    int         run_len;
    logic [3:0] m_digit;
    logic       m_valid, m_new, m_bad;
    logic [7:0] m_err;
    logic [6:0] digit_pat [10];

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (digit_pat[i] == p) return i;
`ifdef SEG7_READER_CHAR_EN
        if (p == 7'b1110110) return 10;
        if (p == 7'b1111001) return 11;
        if (p == 7'b0111000) return 12;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_segq = 0; run_val = 0; run_len = N;
        m_digit = 0; m_valid = 0; m_new = 0; m_bad = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic en, input logic rst);
        int c;
        if (rst) begin
            model_reset();
            return;
        end
        m_new = 0;
        if (en) begin
            if (m_segq == run_val) run_len++;
            else begin
                run_val = m_segq;
                run_len = 1;
            end
            if (run_len == N) begin
                c = decode(run_val);
                if (run_val == 0) begin
                    m_valid = 0; m_bad = 0;
                end else if (c >= 0) begin
                    m_new = (c != int'(m_digit)) || !m_valid;
                    m_digit = c[3:0]; m_valid = 1; m_bad = 0;
                end else begin
                    m_valid = 0; m_bad = 1;
                    if (m_err < 255) m_err = m_err + 1;
                end
            end
        end
        m_segq = s;
    endtask

    task automatic check(input string name, input logic [15:0] want);
        logic [15:0] got;
        got = {digit, digit_valid, new_digit, bad_code, 1'b0, err_count};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got digit=%h valid=%b new=%b bad=%b err=%0d want digit=%h valid=%b new=%b bad=%b err=%0d",
                     name, $time, got[15:12], got[11], got[10], got[9], got[7:0],
                     want[15:12], want[11], want[10], want[9], want[7:0]);
        end
    endtask

    function automatic logic [15:0] pack(input logic [3:0] d, input logic v, input logic n,
                                         input logic b, input logic [7:0] e);
        return {d, v, n, b, 1'b0, e};
    endfunction

    task automatic step(input logic [6:0] s, input logic en, input logic rst, input string name);
        seg_in = s; sample_en = en; clr = rst;
        @(posedge clk);
        model_edge(s, en, rst);
        #1;
        check(name, pack(m_digit, m_valid, m_new, m_bad, m_err));
    endtask

    typedef struct {
        logic [6:0] seg;
        int         hold;
        logic [3:0] e_digit;
        logic       e_valid;
        logic       e_new;
        logic       e_bad;
        logic [7:0] e_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [6:0] s;
        int hold;
        logic en;

        digit_pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

        tbl[0] = '{7'b1101101, 5, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{7'b1001111, 5, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{7'b1111111, 3, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{7'b1001111, 5, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{7'b1010101, 5, 4'd3, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5] = '{7'b0000110, 5, 4'd1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[6] = '{7'b0000000, 5, 4'd1, 1'b0, 1'b0, 1'b0, 8'd1};
`ifdef SEG7_READER_CHAR_EN
        tbl[7] = '{7'b1110110, 5, 4'hA, 1'b1, 1'b1, 1'b0, 8'd1};
`else
        tbl[7] = '{7'b1110110, 5, 4'd1, 1'b0, 1'b0, 1'b1, 8'd2};
`endif

        model_reset();
        step(7'd0, 1'b0, 1'b1, "reset");
        check("reset_values", 16'h0000);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < tbl[r].hold; k++) step(tbl[r].seg, 1'b1, 1'b0, $sformatf("row%0d_cyc%0d", r, k));
            check($sformatf("row%0d_end", r),
                  pack(tbl[r].e_digit, tbl[r].e_valid, tbl[r].e_new, tbl[r].e_bad, tbl[r].e_err));
        end

        // Throttled sampling: one sample_en in four.
        step(7'd0, 1'b0, 1'b1, "thr_reset");
        for (int i = 0; i < 24; i++) begin
            step(7'b1111101, (i % 4) == 0, 1'b0, $sformatf("thr_%0d", i));
            if (i == 15) check("thr_before_commit", pack(4'd0, 1'b0, 1'b0, 1'b0, 8'd0));
            if (i == 16) check("thr_commit", pack(4'd6, 1'b1, 1'b1, 1'b0, 8'd0));
        end
        check("thr_final", pack(4'd6, 1'b1, 1'b0, 1'b0, 8'd0));

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++)
            for (int k = 0; k < N; k++)
                step((i % 2) ? 7'b0101010 : 7'b1010101, 1'b1, 1'b0, "sat");
        for (int k = 0; k < 5; k++) step(7'b0101010, 1'b1, 1'b0, "sat_hold");
        check("sat_255", pack(4'd6, 1'b0, 1'b0, 1'b1, 8'd255));

        // Reset in the middle of settling.
        step(7'b0000110, 1'b1, 1'b0, "mid_a");
        step(7'b0000110, 1'b1, 1'b0, "mid_b");
        step(7'b0000110, 1'b1, 1'b1, "mid_clr");
        check("mid_clr_values", 16'h0000);
        for (int k = 0; k < 5; k++) step(7'b0000110, 1'b1, 1'b0, "post_clr");
        check("post_clr_commit", pack(4'd1, 1'b1, 1'b1, 1'b0, 8'd0));

        // Randomised patterns, holds and sampling.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 13))
                10: s = 7'b0000000;
                11: s = 7'b1110110;
                12: s = 7'b1111001;
                13: s = 7'($urandom);
                default: s = digit_pat[$urandom_range(0, 9)];
            endcase
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                en = ($urandom_range(0, 3) != 0);
                step(s, en, ($urandom_range(0, 199) == 0), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
